multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core: sequences the shared ALU, the unified instruction/data memory port, the instruction register and the register file over several cycles per instruction. It decodes op/funct3/funct7 once per instruction, steps through fetch/decode/execute/memory/writeback states, and drives every datapath select and write enable, including ALUControl and ImmSrc. Supported instructions are lw, sw, R-type, I-type ALU, beq and jal.

---
 rtl/multicycle_controller_if.sv | 37 +++
 rtl/multicycle_controller.sv | 174 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller_if
// Brief    : Instruction fields in, datapath selects and enables out, for
//            the multicycle RV32I control FSM.
// Revision : 1.0
// ============================================================================
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7;
    logic       zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, state
    );

    modport slave (
        output op, funct3, funct7, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_controller
// Brief    : Main control FSM of the multicycle RV32I core (lw, sw, R-type,
//            I-type ALU, beq, jal).
// Revision : 1.0
// ============================================================================
module multicycle_controller (
    input  wire logic              clk,
    input  wire logic              reset,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_MEMADR   = 4'd2;
    localparam logic [3:0] c_MEMREAD  = 4'd3;
    localparam logic [3:0] c_MEMWB    = 4'd4;
    localparam logic [3:0] c_MEMWRITE = 4'd5;
    localparam logic [3:0] c_EXECUTER = 4'd6;
    localparam logic [3:0] c_EXECUTEI = 4'd7;
    localparam logic [3:0] c_ALUWB    = 4'd8;
    localparam logic [3:0] c_BEQ      = 4'd9;
    localparam logic [3:0] c_JAL      = 4'd10;

    localparam logic [6:0] c_OP_LW    = 7'b0000011;
    localparam logic [6:0] c_OP_SW    = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BEQ   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic       w_pcupdate;
    logic       w_branch;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [2:0] w_alucontrol;
    logic [1:0] w_immsrc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_FETCH;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = c_FETCH;
        case (r_state)
            c_FETCH:  w_next_state = c_DECODE;
            c_DECODE: begin
                case (bus.op)
                    c_OP_LW, c_OP_SW: w_next_state = c_MEMADR;
                    c_OP_R:           w_next_state = c_EXECUTER;
                    c_OP_I:           w_next_state = c_EXECUTEI;
                    c_OP_BEQ:         w_next_state = c_BEQ;
                    c_OP_JAL:         w_next_state = c_JAL;
                    default:          w_next_state = c_FETCH;
                endcase
            end
            c_MEMADR:   w_next_state = (bus.op == c_OP_LW) ? c_MEMREAD : c_MEMWRITE;
            c_MEMREAD:  w_next_state = c_MEMWB;
            c_EXECUTER,
            c_EXECUTEI,
            c_JAL:      w_next_state = c_ALUWB;
            default:    w_next_state = c_FETCH;
        endcase
    end

    always_comb begin
        w_pcupdate  = 1'b0;
        w_branch    = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_regwrite  = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        case (r_state)
            c_FETCH: begin
                w_irwrite   = 1'b1;
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_pcupdate  = 1'b1;
            end
            c_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
            end
            c_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
            end
            c_MEMREAD:  w_adrsrc = 1'b1;
            c_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
            end
            c_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
            end
            c_EXECUTER: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
            end
            c_EXECUTEI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
            end
            c_ALUWB:    w_regwrite = 1'b1;
            c_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_branch  = 1'b1;
            end
            c_JAL: begin
                w_alusrca  = 2'b01;
                w_alusrcb  = 2'b10;
                w_pcupdate = 1'b1;
            end
            default: ;
        endcase
    end

    // Subtract only for R-type with funct7[5]; addi with bit 30 set stays add.
    always_comb begin
        w_alucontrol = 3'b000;
        case (w_aluop)
            2'b01: w_alucontrol = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alucontrol = (bus.op[5] & bus.funct7) ? 3'b001 : 3'b000;
                    3'b010:  w_alucontrol = 3'b101;
                    3'b110:  w_alucontrol = 3'b011;
                    3'b111:  w_alucontrol = 3'b010;
                    default: w_alucontrol = 3'b000;
                endcase
            end
            default: w_alucontrol = 3'b000;
        endcase
    end

    always_comb begin
        case (bus.op)
            c_OP_SW:  w_immsrc = 2'b01;
            c_OP_BEQ: w_immsrc = 2'b10;
            c_OP_JAL: w_immsrc = 2'b11;
            default:  w_immsrc = 2'b00;
        endcase
    end

    // Write enables are gated by reset so an in-flight write dies immediately.
    assign bus.PCWrite    = ~reset & (w_pcupdate | (w_branch & bus.zero));
    assign bus.IRWrite    = ~reset & w_irwrite;
    assign bus.RegWrite   = ~reset & w_regwrite;
    assign bus.MemWrite   = ~reset & w_memwrite;
    assign bus.AdrSrc     = w_adrsrc;
    assign bus.ResultSrc  = w_resultsrc;
    assign bus.ALUSrcA    = w_alusrca;
    assign bus.ALUSrcB    = w_alusrcb;
    assign bus.ImmSrc     = w_immsrc;
    assign bus.ALUControl = w_alucontrol;
    assign bus.state      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Self-checking bench for the multicycle RV32I control FSM.
// Revision : 1.0
// ============================================================================
module tb_multicycle_controller;
    localparam logic [6:0] c_LW  = 7'b0000011;
    localparam logic [6:0] c_SW  = 7'b0100011;
    localparam logic [6:0] c_R   = 7'b0110011;
    localparam logic [6:0] c_I   = 7'b0010011;
    localparam logic [6:0] c_BEQ = 7'b1100011;
    localparam logic [6:0] c_JAL = 7'b1101111;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU operation an executing instruction asks for, by mnemonic.
    function automatic logic [2:0] exec_alu(input logic [6:0] op, input logic [2:0] f3,
                                            input logic f7);
        logic [2:0] add_op, sub_op, and_op, or_op, slt_op;
        add_op = 3'b000; sub_op = 3'b001; and_op = 3'b010; or_op = 3'b011; slt_op = 3'b101;
        case (f3)
            3'b000:  return (op == c_R && f7) ? sub_op : add_op;
            3'b010:  return slt_op;
            3'b110:  return or_op;
            3'b111:  return and_op;
            default: return add_op;
        endcase
    endfunction

    function automatic logic [1:0] imm_kind(input logic [6:0] op);
        if (op == c_SW)  return 2'b01;
        if (op == c_BEQ) return 2'b10;
        if (op == c_JAL) return 2'b11;
        return 2'b00;
    endfunction

    // Packed {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl}.
    function automatic logic [15:0] model_outputs(input int st, input logic [6:0] op,
                                                  input logic [2:0] f3, input logic f7,
                                                  input logic z);
        logic pcw, adr, mw, irw, rw;
        logic [1:0] res, sa, sb;
        logic [2:0] alu;
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; res = 0; sa = 0; sb = 0; alu = 0;
        case (st)
            0:  begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
            1:  begin sa = 2'b01; sb = 2'b01; end
            2:  begin sa = 2'b10; sb = 2'b01; end
            3:  adr = 1;
            4:  begin res = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  begin sa = 2'b10; alu = exec_alu(op, f3, f7); end
            7:  begin sa = 2'b10; sb = 2'b01; alu = exec_alu(op, f3, f7); end
            8:  rw = 1;
            9:  begin sa = 2'b10; alu = 3'b001; pcw = z; end
            10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, adr, mw, irw, res, sa, sb, imm_kind(op), rw, alu};
    endfunction

    // Runs one instruction from FETCH, checking every cycle against the model.
    task automatic test_instruction(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                    input logic z, input string tag);
        int seq[$];
        logic [15:0] exp_v, got_v;
        seq.push_back(0);
        seq.push_back(1);
        case (op)
            c_LW:    begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            c_SW:    begin seq.push_back(2); seq.push_back(5); end
            c_R:     begin seq.push_back(6); seq.push_back(8); end
            c_I:     begin seq.push_back(7); seq.push_back(8); end
            c_BEQ:   seq.push_back(9);
            c_JAL:   begin seq.push_back(10); seq.push_back(8); end
            default: ;
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            bus.op = op; bus.funct3 = f3; bus.funct7 = f7;
            bus.zero = (seq[i] == 9) ? z : 1'($urandom);
            #1;
            exp_v = model_outputs(seq[i], op, f3, f7, bus.zero);
            got_v = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
                     bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegWrite, bus.ALUControl};
            n_cmp++;
            if (bus.state !== 4'(seq[i])) begin
                n_fail++;
                $display("FAIL %s cycle %0d state: got %0d expected %0d", tag, i, bus.state, seq[i]);
            end
            n_cmp++;
            if (got_v !== exp_v) begin
                n_fail++;
                $display("FAIL %s cycle %0d outputs: got %b expected %b", tag, i, got_v, exp_v);
            end
            @(posedge clk); #1;
        end
        n_cmp++;
        if (bus.state !== 4'd0) begin
            n_fail++;
            $display("FAIL %s return_to_fetch: got %0d expected 0", tag, bus.state);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.op = c_LW; bus.funct3 = 3'($urandom); bus.funct7 = 1'b1; bus.zero = 1'b1;
        #1;
        n_cmp++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL reset_async state: got %0d expected 0", bus.state);
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_enables: got %b expected 0000",
                               {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
        end
        n_cmp++;
        if ({bus.state, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl}
                !== {4'd0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000}) begin
            n_fail++; $display("FAIL reset_selects: got %b expected 0000_0_00_10_10_000",
                               {bus.state, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc, bus.ALUControl});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.PCWrite, bus.IRWrite} !== 2'b11) begin
            n_fail++; $display("FAIL reset_release_fetch: got %b expected 11", {bus.PCWrite, bus.IRWrite});
        end
    endtask

    task automatic test_directed();
        test_instruction(c_LW,  3'b010, 1'b0, 1'b0, "lw");
        test_instruction(c_SW,  3'b010, 1'b0, 1'b0, "sw");
        test_instruction(c_R,   3'b000, 1'b1, 1'b0, "sub");
        test_instruction(c_R,   3'b000, 1'b0, 1'b0, "add");
        test_instruction(c_R,   3'b111, 1'b0, 1'b0, "and");
        test_instruction(c_R,   3'b010, 1'b0, 1'b0, "slt");
        test_instruction(c_R,   3'b110, 1'b0, 1'b0, "or");
        test_instruction(c_I,   3'b000, 1'b1, 1'b0, "addi_bit30");
        test_instruction(c_BEQ, 3'b000, 1'b0, 1'b1, "beq_taken");
        test_instruction(c_BEQ, 3'b000, 1'b0, 1'b0, "beq_not_taken");
        test_instruction(c_JAL, 3'b000, 1'b0, 1'b0, "jal");
        test_instruction(7'b1111111, 3'b000, 1'b0, 1'b0, "unsupported");
    endtask

    task automatic test_reset_midwrite();
        bus.op = c_SW; bus.funct3 = 3'b010; bus.funct7 = 1'b0; bus.zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.state, bus.MemWrite} !== {4'd5, 1'b1}) begin
            n_fail++; $display("FAIL midwrite_entry: got state %0d mw %b expected 5 1", bus.state, bus.MemWrite);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.state, bus.MemWrite} !== {4'd0, 1'b0}) begin
            n_fail++; $display("FAIL midwrite_abort: got state %0d mw %b expected 0 0", bus.state, bus.MemWrite);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.state, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite} !== 8'h00) begin
            n_fail++; $display("FAIL midwrite_hold: got %b expected 00000000",
                               {bus.state, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] op;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 6))
                0: op = c_LW;
                1: op = c_SW;
                2: op = c_R;
                3: op = c_I;
                4: op = c_BEQ;
                5: op = c_JAL;
                default: op = 7'($urandom);
            endcase
            test_instruction(op, 3'($urandom), 1'($urandom), 1'($urandom), "random");
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        test_reset();
        test_directed();
        test_reset_midwrite();
        test_instruction(c_LW, 3'b010, 1'b0, 1'b0, "lw_after_reset");
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
